sa_result_drain: RTL and testbench

Output stage of the systolic array, directly downstream of the array configuration/sequencer block. On the sequencer's one-cycle `cal_done` pulse it snapshots all X×Y PE accumulator results into a local buffer, pulses a clear to the PE accumulators, then streams the results out one element per accepted beat, in row-major order, over a valid/ready interface. The snapshot frees the array for the next `SA_start` while the drain is still in progress.

---
 rtl/sa_result_drain.sv | 120 ++++++++++++
 tb/tb_sa_result_drain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - snapshot PE results on cal_done and stream them out row-major
module sa_result_drain #(
    parameter int X     = 3,
    parameter int Y     = 3,
    parameter int RES_W = 16,
    parameter int IDX_W = (X * Y > 1) ? $clog2(X * Y) : 1
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   cal_done,
    input  logic [X*Y*RES_W-1:0]   pe_res,
    input  logic                   out_ready,
    input  logic                   clr_overrun,
    output logic [RES_W-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   acc_clr,
    output logic                   busy,
    output logic                   drain_done,
    output logic                   overrun
);

    localparam int N = X * Y;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [RES_W-1:0] buf_q [N];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acc_clr_q, acc_clr_d;
    logic             drain_done_q, drain_done_d;
    logic             overrun_q, overrun_d;

    logic accept;
    logic last_accept;
    logic capture;
    logic overrun_hit;

    // A capture is only legal when the buffer is free or being vacated this very cycle.
    always_comb begin
        accept      = (state_q == S_STREAM) && out_ready;
        last_accept = accept && (idx_q == LAST_IDX);
        capture     = cal_done && ((state_q == S_IDLE) || last_accept);
        overrun_hit = cal_done && (state_q == S_STREAM) && !last_accept;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cal_done) state_d = S_STREAM;
            S_STREAM: if (last_accept && !cal_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (capture) begin
            idx_d = '0;
        end else if (accept && !last_accept) begin
            idx_d = idx_q + IDX_W'(1);
        end
        acc_clr_d    = capture;
        drain_done_d = last_accept;
        overrun_d    = overrun_q;
        if (overrun_hit) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            idx_q        <= '0;
            acc_clr_q    <= 1'b0;
            drain_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            acc_clr_q    <= acc_clr_d;
            drain_done_q <= drain_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Buffer contents are don't-care until the first capture, so no reset here.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= pe_res[k*RES_W +: RES_W];
            end
        end
    end

    always_comb begin
        out_valid  = (state_q == S_STREAM);
        busy       = (state_q == S_STREAM);
        out_data   = out_valid ? buf_q[idx_q] : '0;
        out_idx    = out_valid ? idx_q : '0;
        out_last   = out_valid && (idx_q == LAST_IDX);
        acc_clr    = acc_clr_q;
        drain_done = drain_done_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// tb/tb_sa_result_drain.sv - queue-model checked bench for sa_result_drain (3x3 and 2x4)
module tb_sa_result_drain;

    logic clk = 1'b0;
    logic rst;
    logic calA, rdyA, clrA, calB, rdyB, clrB;
    logic [143:0] peresA;
    logic [127:0] peresB;

    logic [15:0] odA, odB;
    logic        ovA, olA, accA, bsA, ddA, orA;
    logic        ovB, olB, accB, bsB, ddB, orB;
    logic [3:0]  oiA;
    logic [2:0]  oiB;

    int peA [9];
    int peB [8];

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    int qd [2][$];
    int qi [2][$];
    int e_acc [2];
    int e_dd  [2];
    int e_ovr [2];

    int logA [$];
    int logB [$];
    int lastB [$];
    int ddcntA, clrcntA, ddcntB;

    always #5 clk = ~clk;

    always_comb begin
        peresA = '0;
        for (int k = 0; k < 9; k++) peresA[k*16 +: 16] = 16'(peA[k]);
    end

    always_comb begin
        peresB = '0;
        for (int k = 0; k < 8; k++) peresB[k*16 +: 16] = 16'(peB[k]);
    end

    sa_result_drain #(.X(3), .Y(3), .RES_W(16)) dut_a (
        .clk(clk), .sys_rst(rst), .cal_done(calA), .pe_res(peresA),
        .out_ready(rdyA), .clr_overrun(clrA), .out_data(odA), .out_valid(ovA),
        .out_last(olA), .out_idx(oiA), .acc_clr(accA), .busy(bsA),
        .drain_done(ddA), .overrun(orA)
    );

    sa_result_drain #(.X(2), .Y(4), .RES_W(16)) dut_b (
        .clk(clk), .sys_rst(rst), .cal_done(calB), .pe_res(peresB),
        .out_ready(rdyB), .clr_overrun(clrB), .out_data(odB), .out_valid(ovB),
        .out_last(olB), .out_idx(oiB), .acc_clr(accB), .busy(bsB),
        .drain_done(ddB), .overrun(orB)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pending elements live in a queue; a capture is allowed only when the queue drains empty.
    task automatic model_step(input int u, input bit cal, input bit rdy, input bit clr, input int n);
        bit acc_b, last_b;
        if (rst) begin
            qd[u].delete();
            qi[u].delete();
            e_acc[u] = 0; e_dd[u] = 0; e_ovr[u] = 0;
            return;
        end
        acc_b  = (qd[u].size() > 0) && rdy;
        last_b = acc_b && (qi[u][0] == n - 1);
        if (acc_b) begin
            void'(qd[u].pop_front());
            void'(qi[u].pop_front());
        end
        e_dd[u]  = int'(last_b);
        e_acc[u] = 0;
        if (clr) e_ovr[u] = 0;
        if (cal) begin
            if (qd[u].size() == 0) begin
                for (int k = 0; k < n; k++) begin
                    if (u == 0) qd[u].push_back(peA[k]);
                    else        qd[u].push_back(peB[k]);
                    qi[u].push_back(k);
                end
                e_acc[u] = 1;
            end else begin
                e_ovr[u] = 1;
            end
        end
    endtask

    task automatic cmp_unit(input string p, input int u, input int n,
                            input int v, input int d, input int l, input int i,
                            input int a, input int b, input int dd, input int o);
        int ev, ed, ei;
        ev = (qd[u].size() > 0) ? 1 : 0;
        ed = ev ? qd[u][0] : 0;
        ei = ev ? qi[u][0] : 0;
        check({p, "_valid"}, v, ev);
        check({p, "_data"}, d, ed);
        check({p, "_idx"}, i, ei);
        check({p, "_last"}, l, (ev != 0 && ei == n - 1) ? 1 : 0);
        check({p, "_busy"}, b, ev);
        check({p, "_acc_clr"}, a, e_acc[u]);
        check({p, "_drain_done"}, dd, e_dd[u]);
        check({p, "_overrun"}, o, e_ovr[u]);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp_unit("A", 0, 9, int'(ovA), int'(odA), int'(olA), int'(oiA),
                     int'(accA), int'(bsA), int'(ddA), int'(orA));
            cmp_unit("B", 1, 8, int'(ovB), int'(odB), int'(olB), int'(oiB),
                     int'(accB), int'(bsB), int'(ddB), int'(orB));
            if (ovA && rdyA) logA.push_back(int'(odA));
            if (ovB && rdyB) logB.push_back(int'(odB));
            if (ovB && rdyB && olB) lastB.push_back(int'(oiB));
            if (ddA) ddcntA++;
            if (accA) clrcntA++;
            if (ddB) ddcntB++;
        end
        model_step(0, calA, rdyA, clrA, 9);
        model_step(1, calB, rdyB, clrB, 8);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        logA.delete(); logB.delete(); lastB.delete();
        ddcntA = 0; clrcntA = 0; ddcntB = 0;
    endtask

    task automatic set_peA(input int base);
        for (int k = 0; k < 9; k++) peA[k] = base + k;
    endtask

    task automatic check_logA(input string name, input int base, input int offset, input int len);
        for (int k = 0; k < len; k++) begin
            if (offset + k < logA.size()) check(name, logA[offset + k], base + k);
            else check(name, -1, base + k);
        end
    endtask

    initial begin
        rst = 1'b1;
        calA = 0; rdyA = 0; clrA = 0; calB = 0; rdyB = 0; clrB = 0;
        set_peA(0);
        for (int k = 0; k < 8; k++) peB[k] = 0;
        clear_logs();
        tick();
        armed = 1'b1;
        tick();
        check("rst_valid", int'(ovA), 0);
        check("rst_data", int'(odA), 0);
        check("rst_overrun", int'(orA), 0);
        check("rst_busy", int'(bsA), 0);
        rst = 1'b0;
        tick();

        // basic drain
        clear_logs();
        set_peA(1);
        calA = 1; rdyA = 1;
        tick();
        calA = 0;
        check("basic_first_data", int'(odA), 1);
        check("basic_first_idx", int'(oiA), 0);
        check("basic_acc_clr", int'(accA), 1);
        check("basic_busy", int'(bsA), 1);
        repeat (9) tick();
        check("basic_done", int'(ddA), 1);
        check("basic_busy_end", int'(bsA), 0);
        tick();
        check("basic_log_len", logA.size(), 9);
        check_logA("basic_log", 1, 0, 9);
        check("basic_dd_count", ddcntA, 1);
        check("basic_clr_count", clrcntA, 1);

        // backpressure
        clear_logs();
        calA = 1; rdyA = 1;
        tick();
        calA = 0;
        for (int i = 0; i < 26; i++) begin
            rdyA = (i % 2 == 0);
            tick();
        end
        rdyA = 1;
        tick();
        check("bp_log_len", logA.size(), 9);
        check_logA("bp_log", 1, 0, 9);
        check("bp_dd_count", ddcntA, 1);

        // back-to-back
        clear_logs();
        calA = 1; rdyA = 1;
        tick();
        calA = 0;
        repeat (8) tick();
        check("b2b_last_idx", int'(oiA), 8);
        set_peA(11);
        calA = 1;
        tick();
        calA = 0;
        check("b2b_data", int'(odA), 11);
        check("b2b_idx", int'(oiA), 0);
        check("b2b_acc_clr", int'(accA), 1);
        check("b2b_overrun", int'(orA), 0);
        check("b2b_done", int'(ddA), 1);
        repeat (10) tick();
        check("b2b_log_len", logA.size(), 18);
        check_logA("b2b_log1", 1, 0, 9);
        check_logA("b2b_log2", 11, 9, 9);
        check("b2b_dd_count", ddcntA, 2);
        check("b2b_clr_count", clrcntA, 2);

        // overrun
        clear_logs();
        set_peA(1);
        calA = 1; rdyA = 1;
        tick();
        calA = 0;
        repeat (3) tick();
        rdyA = 0;
        set_peA(31);
        calA = 1;
        tick();
        calA = 0;
        check("ovr_set", int'(orA), 1);
        check("ovr_data", int'(odA), 4);
        check("ovr_no_clr", int'(accA), 0);
        rdyA = 1;
        repeat (3) tick();
        check("ovr_sticky", int'(orA), 1);
        clrA = 1;
        tick();
        clrA = 0;
        check("ovr_cleared", int'(orA), 0);
        repeat (7) tick();
        check("ovr_log_len", logA.size(), 9);
        check_logA("ovr_log", 1, 0, 9);
        check("ovr_clr_count", clrcntA, 1);
        check("ovr_dd_count", ddcntA, 1);

        // reset mid-stream
        clear_logs();
        set_peA(1);
        calA = 1; rdyA = 1;
        tick();
        calA = 0;
        repeat (4) tick();
        check("rms_beat5", int'(odA), 5);
        rst = 1;
        tick();
        rst = 0;
        check("rms_valid", int'(ovA), 0);
        check("rms_data", int'(odA), 0);
        check("rms_idx", int'(oiA), 0);
        check("rms_busy", int'(bsA), 0);
        check("rms_done", int'(ddA), 0);
        tick();
        tick();
        check("rms_dd_count", ddcntA, 0);
        calA = 1;
        tick();
        calA = 0;
        check("rms_restart_data", int'(odA), 1);
        check("rms_restart_idx", int'(oiA), 0);
        repeat (10) tick();

        // non-square 2x4
        clear_logs();
        for (int k = 0; k < 8; k++) peB[k] = 101 + k;
        calB = 1; rdyB = 1;
        tick();
        calB = 0;
        repeat (9) tick();
        check("ns_log_len", logB.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < logB.size()) check("ns_log", logB[k], 101 + k);
            else check("ns_log", -1, 101 + k);
        end
        check("ns_last_count", lastB.size(), 1);
        if (lastB.size() > 0) check("ns_last_idx", lastB[0], 7);
        check("ns_dd_count", ddcntB, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
